uart_byte_tx: RTL and testbench

Serializes the 8-bit value produced by the chip's input/output datapath onto a single UART TX line: 8N1 by default, with optional even parity and two stop bits. It sits directly downstream of the byte-wide top-level datapath and consumes one byte per valid/ready handshake. The frame is driven on one dedicated output pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_byte_tx.sv | 133 +++++++++++++
 tb/tb_uart_byte_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, with a one-cycle
// tick on the last count of every bit period.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 10,
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    logic [CW-1:0] count;

    assign bit_tick = enable && (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            if (bit_tick) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide valid/ready UART transmitter: 8 data bits LSB first, optional even
// parity, one or two stop bits. tx and busy are registered.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 10_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned PARITY_EN = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("uart_byte_tx: illegal CLKS_PER_BIT or STOP_BITS");
    end

    tx_state_t state, state_d;
    logic [DATA_BITS-1:0] sreg, sreg_d;
    logic [2:0]           idx, idx_d;
    logic                 par_q, par_d;
    logic                 tx_d, busy_d;
    logic                 bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (state != IDLE),
        .bit_tick(bit_tick)
    );

    assign ready_out = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
            par_q <= 1'b0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            sreg  <= sreg_d;
            idx   <= idx_d;
            par_q <= par_d;
            tx    <= tx_d;
            busy  <= busy_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx lines up with
    // state without a combinational output path.
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        idx_d   = idx;
        par_d   = par_q;
        tx_d    = tx;
        unique case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (valid_in) begin
                    state_d = START;
                    sreg_d  = data_in;
                    par_d   = ^data_in;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = sreg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d  = idx + 3'd1;
                        sreg_d = sreg >> 1;
                        tx_d   = sreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (idx == 3'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at 10 clocks per bit: one 8N1 instance and
// one even-parity, two-stop-bit instance.
module tb_uart_byte_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, tx, busy;
    logic [7:0] data_p = 8'h00;
    logic       valid_p = 1'b0;
    logic       ready_p, tx_p, busy_p;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_byte_tx #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .PARITY_EN(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .busy(busy)
    );

    uart_byte_tx #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .STOP_BITS(2)
    ) dut_p (
        .clk(clk), .rst(rst), .data_in(data_p), .valid_in(valid_p),
        .ready_out(ready_p), .tx(tx_p), .busy(busy_p)
    );

    // Expected line level k cycles after the accept edge (k=0 is first start cycle).
    function automatic logic exp_tx(input logic [7:0] b, input int par_en, input int k);
        int slot;
        slot = k / 10;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (par_en != 0 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ready_out && ready_p) && n < 400) begin
            step();
            n++;
        end
        tests_run++;
        if (!(ready_out && ready_p)) begin
            tests_failed++;
            $display("FAIL wait_idle: ready=%b ready_p=%b required 1 1 within 400 cycles", ready_out, ready_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b1;
        data_in = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({tx, busy, ready_out} !== 3'b101) begin
                tests_failed++;
                $display("FAIL reset_state cyc%0d: tx,busy,ready=%b required 101", i, {tx, busy, ready_out});
            end
            tests_run++;
            if ({tx_p, busy_p, ready_p} !== 3'b101) begin
                tests_failed++;
                $display("FAIL reset_state_p cyc%0d: tx,busy,ready=%b required 101", i, {tx_p, busy_p, ready_p});
            end
        end
        rst = 1'b0;
        step();
        valid_in = 1'b0;
        tests_run++;
        if ({tx, busy, ready_out} !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_release_start: tx,busy,ready=%b required 010", {tx, busy, ready_out});
        end
        wait_idle();
    endtask

    task automatic test_basic();
        logic [7:0] b;
        b = 8'hA5;
        data_in = b;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        data_in = 8'h00;
        for (int k = 0; k < 100; k++) begin
            tests_run++;
            if ({tx, busy, ready_out} !== {exp_tx(b, 0, k), 2'b10}) begin
                tests_failed++;
                $display("FAIL basic_a5 k=%0d: tx,busy,ready=%b required %b", k, {tx, busy, ready_out}, {exp_tx(b, 0, k), 2'b10});
            end
            step();
        end
        tests_run++;
        if ({tx, busy, ready_out} !== 3'b101) begin
            tests_failed++;
            $display("FAIL basic_end T+101: tx,busy,ready=%b required 101", {tx, busy, ready_out});
        end
    endtask

    task automatic test_back_to_back();
        data_in = 8'h00;
        valid_in = 1'b1;
        step();
        data_in = 8'hFF;
        for (int k = 0; k < 100; k++) begin
            tests_run++;
            if (tx !== exp_tx(8'h00, 0, k)) begin
                tests_failed++;
                $display("FAIL b2b_first k=%0d: tx=%b required %b", k, tx, exp_tx(8'h00, 0, k));
            end
            step();
        end
        tests_run++;
        if ({tx, ready_out} !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_gap: tx,ready=%b required 11", {tx, ready_out});
        end
        step();
        valid_in = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tests_run++;
            if (tx !== exp_tx(8'hFF, 0, k)) begin
                tests_failed++;
                $display("FAIL b2b_second k=%0d: tx=%b required %b", k, tx, exp_tx(8'hFF, 0, k));
            end
            step();
        end
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_end: ready=%b required 1", ready_out);
        end
    endtask

    task automatic test_parity();
        logic [7:0] vecs [2];
        logic       pbit [2];
        vecs[0] = 8'h07; pbit[0] = 1'b1;
        vecs[1] = 8'h03; pbit[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            data_p = vecs[v];
            valid_p = 1'b1;
            step();
            valid_p = 1'b0;
            for (int k = 0; k < 120; k++) begin
                tests_run++;
                if ({tx_p, busy_p, ready_p} !== {exp_tx(vecs[v], 1, k), 2'b10}) begin
                    tests_failed++;
                    $display("FAIL parity_frame %h k=%0d: tx,busy,ready=%b required %b", vecs[v], k, {tx_p, busy_p, ready_p}, {exp_tx(vecs[v], 1, k), 2'b10});
                end
                if (k == 95) begin
                    tests_run++;
                    if (tx_p !== pbit[v]) begin
                        tests_failed++;
                        $display("FAIL parity_bit %h: tx=%b required %b", vecs[v], tx_p, pbit[v]);
                    end
                end
                step();
            end
            tests_run++;
            if ({tx_p, busy_p, ready_p} !== 3'b101) begin
                tests_failed++;
                $display("FAIL parity_len %h at 121: tx,busy,ready=%b required 101", vecs[v], {tx_p, busy_p, ready_p});
            end
        end
    endtask

    task automatic test_ignored();
        data_in = 8'h81;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 30) begin
                data_in = 8'h3C;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            tests_run++;
            if (tx !== exp_tx(8'h81, 0, k)) begin
                tests_failed++;
                $display("FAIL ignored_frame k=%0d: tx=%b required %b", k, tx, exp_tx(8'h81, 0, k));
            end
            step();
        end
        valid_in = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tests_run++;
            if ({tx, busy, ready_out} !== 3'b101) begin
                tests_failed++;
                $display("FAIL ignored_after k=%0d: tx,busy,ready=%b required 101", k, {tx, busy, ready_out});
            end
            step();
        end
    endtask

    task automatic test_abort();
        data_in = 8'h55;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int k = 0; k < 55; k++) step();
        tests_run++;
        if (tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_bit4: tx=%b required 1", tx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if ({tx, busy, ready_out} !== 3'b101) begin
            tests_failed++;
            $display("FAIL abort_state: tx,busy,ready=%b required 101", {tx, busy, ready_out});
        end
        for (int k = 0; k < 200; k++) begin
            step();
            tests_run++;
            if (tx !== 1'b1) begin
                tests_failed++;
                $display("FAIL abort_quiet k=%0d: tx=%b required 1", k, tx);
            end
        end
    endtask

    initial begin
        test_reset();
        wait_idle();
        test_basic();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_parity();
        wait_idle();
        test_ignored();
        wait_idle();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, required completion before 5ms");
        $fatal(1, "timeout");
    end

endmodule
